// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences trap/xRET CSR writes, privilege change and fetch redirect
package def_pkg;
  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;
  localparam logic [63:0] SMODE_STATUS_WRITE_MASK = 64'h8000_0003_000D_E762;
endpackage

module trap_sequencer #(
  parameter int XLEN   = 64,
  parameter bit VEC_EN = 1'b1
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  def_pkg::exception_t exc_i,
  input  logic [XLEN-1:0]     exc_pc_i,
  input  logic                xret_valid_i,
  input  logic                xret_is_mret_i,
  output logic                ready_o,
  input  logic [XLEN-1:0]     mstatus_i,
  input  logic [XLEN-1:0]     medeleg_i,
  input  logic [XLEN-1:0]     mideleg_i,
  input  logic [XLEN-1:0]     mtvec_i,
  input  logic [XLEN-1:0]     stvec_i,
  input  logic [XLEN-1:0]     mepc_i,
  input  logic [XLEN-1:0]     sepc_i,
  output logic                csr_we_o,
  output logic [11:0]         csr_addr_o,
  output logic [XLEN-1:0]     csr_wdata_o,
  output logic [1:0]          priv_lvl_o,
  output logic                flush_o,
  output logic                redirect_valid_o,
  output logic [XLEN-1:0]     redirect_pc_o
);
  import def_pkg::*;

  typedef enum logic [2:0] {IDLE, W_CAUSE, W_EPC, W_TVAL, W_STATUS, REDIRECT} state_t;

  state_t          state, state_nx;
  logic [1:0]      priv_q;
  logic [XLEN-1:0] cause_q, tval_q, epc_q, status_q, pc_q;
  logic            to_s_q;
  logic [1:0]      new_priv_q;

  logic            take, intr, deleg;
  logic [5:0]      idx;
  logic [XLEN-1:0] tvec, tbase, tvec_pc;
  logic [XLEN-1:0] m_st, s_st, mret_st, sret_st, acc_status, acc_pc;
  logic [1:0]      acc_priv;

  assign take  = (state == IDLE) && (exc_i.valid || xret_valid_i);
  assign intr  = exc_i.cause[63];
  assign idx   = exc_i.cause[5:0];
  assign deleg = (priv_q != 2'b11) && (intr ? mideleg_i[idx] : medeleg_i[idx]);
  assign tvec  = deleg ? stvec_i : mtvec_i;
  assign tbase = {tvec[XLEN-1:2], 2'b00};
  assign tvec_pc = (VEC_EN && tvec[1:0] == 2'b01 && intr)
                 ? tbase + {{(XLEN-8){1'b0}}, idx, 2'b00} : tbase;

  // New mstatus images for each kind of operation, built from the live CSR value at acceptance
  always_comb begin
    m_st          = mstatus_i;
    m_st[7]       = mstatus_i[3];
    m_st[3]       = 1'b0;
    m_st[12:11]   = priv_q;
    s_st          = mstatus_i;
    s_st[5]       = mstatus_i[1];
    s_st[1]       = 1'b0;
    s_st[8]       = priv_q[0];
    s_st          = (mstatus_i & ~SMODE_STATUS_WRITE_MASK) | (s_st & SMODE_STATUS_WRITE_MASK);
    mret_st       = mstatus_i;
    mret_st[3]    = mstatus_i[7];
    mret_st[7]    = 1'b1;
    mret_st[12:11] = 2'b00;
    mret_st[17]   = (mstatus_i[12:11] == 2'b11) ? mstatus_i[17] : 1'b0;
    sret_st       = mstatus_i;
    sret_st[1]    = mstatus_i[5];
    sret_st[5]    = 1'b1;
    sret_st[8]    = 1'b0;
    sret_st[17]   = 1'b0;
  end

  // Select what gets latched: the exception wins over a simultaneous xRET
  always_comb begin
    acc_status = exc_i.valid ? (deleg ? s_st : m_st) : (xret_is_mret_i ? mret_st : sret_st);
    acc_pc     = exc_i.valid ? tvec_pc : (xret_is_mret_i ? mepc_i : sepc_i);
    acc_priv   = exc_i.valid ? (deleg ? 2'b01 : 2'b11)
               : (xret_is_mret_i ? mstatus_i[12:11] : {1'b0, mstatus_i[8]});
  end

  // State register and current privilege, which changes only as REDIRECT completes
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      priv_q <= 2'b11;
    end else begin
      state  <= state_nx;
      priv_q <= (state == REDIRECT) ? new_priv_q : priv_q;
    end
  end

  // Operation context captured once at acceptance so later input changes cannot disturb it
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cause_q    <= '0;
      tval_q     <= '0;
      epc_q      <= '0;
      status_q   <= '0;
      pc_q       <= '0;
      to_s_q     <= 1'b0;
      new_priv_q <= 2'b11;
    end else if (take) begin
      cause_q    <= exc_i.cause;
      tval_q     <= exc_i.tval;
      epc_q      <= {exc_pc_i[XLEN-1:2], 2'b00};
      status_q   <= acc_status;
      pc_q       <= acc_pc;
      to_s_q     <= exc_i.valid && deleg;
      new_priv_q <= acc_priv;
    end
  end

  // Next-state sequencing: traps walk all four writes, xRETs only the status write
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     state_nx = exc_i.valid ? W_CAUSE : (xret_valid_i ? W_STATUS : IDLE);
      W_CAUSE:  state_nx = W_EPC;
      W_EPC:    state_nx = W_TVAL;
      W_TVAL:   state_nx = W_STATUS;
      W_STATUS: state_nx = REDIRECT;
      REDIRECT: state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Output decode: one CSR write per W_* state, zeroed buses elsewhere
  always_comb begin
    csr_we_o    = (state == W_CAUSE) || (state == W_EPC) || (state == W_TVAL) || (state == W_STATUS);
    csr_addr_o  = (state == W_CAUSE)  ? (to_s_q ? 12'h142 : 12'h342)
                : (state == W_EPC)    ? (to_s_q ? 12'h141 : 12'h341)
                : (state == W_TVAL)   ? (to_s_q ? 12'h143 : 12'h343)
                : (state == W_STATUS) ? 12'h300 : 12'h000;
    csr_wdata_o = (state == W_CAUSE)  ? cause_q
                : (state == W_EPC)    ? epc_q
                : (state == W_TVAL)   ? tval_q
                : (state == W_STATUS) ? status_q : '0;
    redirect_valid_o = (state == REDIRECT);
    redirect_pc_o    = (state == REDIRECT) ? pc_q : '0;
    ready_o          = (state == IDLE);
    flush_o          = (state != IDLE);
    priv_lvl_o       = priv_q;
  end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed and randomized checks of trap_sequencer against a cycle-level model
module tb_trap_sequencer;
  import def_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  exception_t  exc;
  logic [63:0] exc_pc, mstatus, medeleg, mideleg, mtvec, stvec, mepc, sepc;
  logic        xret_valid, xret_is_mret;
  logic        ready, csr_we, flush, rv;
  logic [11:0] csr_addr;
  logic [63:0] csr_wdata, rpc;
  logic [1:0]  priv;

  trap_sequencer dut (
    .clk_i(clk), .rstn_i(rstn), .exc_i(exc), .exc_pc_i(exc_pc),
    .xret_valid_i(xret_valid), .xret_is_mret_i(xret_is_mret), .ready_o(ready),
    .mstatus_i(mstatus), .medeleg_i(medeleg), .mideleg_i(mideleg),
    .mtvec_i(mtvec), .stvec_i(stvec), .mepc_i(mepc), .sepc_i(sepc),
    .csr_we_o(csr_we), .csr_addr_o(csr_addr), .csr_wdata_o(csr_wdata),
    .priv_lvl_o(priv), .flush_o(flush), .redirect_valid_o(rv), .redirect_pc_o(rpc)
  );

  typedef struct packed {
    logic        ready;
    logic        flush;
    logic        we;
    logic [11:0] addr;
    logic [63:0] data;
    logic        rv;
    logic [63:0] rpc;
    logic [1:0]  priv;
  } obs_t;

  obs_t       q[$];
  obs_t       cap[8];
  logic [1:0] mp;
  bit         cur_idle;
  int         n_chk = 0;
  int         n_pass = 0;

  function automatic obs_t mk(bit busy, bit we, logic [11:0] a, logic [63:0] d, bit r, logic [63:0] pc);
    obs_t o;
    o.ready = !busy;
    o.flush = busy;
    o.we    = we;
    o.addr  = a;
    o.data  = d;
    o.rv    = r;
    o.rpc   = pc;
    o.priv  = mp;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic clr();
    exc = '0; exc_pc = '0; mstatus = '0; medeleg = '0; mideleg = '0;
    mtvec = '0; stvec = '0; mepc = '0; sepc = '0; xret_valid = 0; xret_is_mret = 0;
  endtask

  task automatic randomize_inputs();
    exc.cause  = {$urandom, $urandom};
    exc.tval   = {$urandom, $urandom};
    exc.valid  = ($urandom_range(0, 99) < 35);
    exc_pc     = {$urandom, $urandom};
    xret_valid = ($urandom_range(0, 99) < 30);
    xret_is_mret = $urandom_range(0, 1);
    mstatus = {$urandom, $urandom};
    medeleg = {$urandom, $urandom};
    mideleg = {$urandom, $urandom};
    mtvec   = {$urandom, $urandom};
    stvec   = {$urandom, $urandom};
    mepc    = {$urandom, $urandom};
    sepc    = {$urandom, $urandom};
  endtask

  // Expected per-cycle outputs of one accepted request, derived from the trap/xRET rules
  task automatic model_accept();
    logic [63:0] st, tv, vec;
    logic [5:0]  idx;
    logic [1:0]  np;
    bit          s, intr;
    if (!cur_idle) return;
    if (exc.valid) begin
      intr = exc.cause[63];
      idx  = exc.cause[5:0];
      s    = (mp != 2'b11) && (intr ? mideleg[idx] : medeleg[idx]);
      tv   = s ? stvec : mtvec;
      vec  = {tv[63:2], 2'b00} + ((tv[1:0] == 2'b01 && intr) ? 64'(idx) * 64'd4 : 64'd0);
      st   = mstatus;
      if (s) begin st[5] = st[1]; st[1] = 1'b0; st[8] = mp[0]; end
      else begin st[7] = st[3]; st[3] = 1'b0; st[12:11] = mp; end
      q.push_back(mk(1, 1, s ? 12'h142 : 12'h342, exc.cause, 0, 0));
      q.push_back(mk(1, 1, s ? 12'h141 : 12'h341, {exc_pc[63:2], 2'b00}, 0, 0));
      q.push_back(mk(1, 1, s ? 12'h143 : 12'h343, exc.tval, 0, 0));
      q.push_back(mk(1, 1, 12'h300, st, 0, 0));
      q.push_back(mk(1, 0, 12'h000, 0, 1, vec));
      mp = s ? 2'b01 : 2'b11;
    end else if (xret_valid) begin
      st = mstatus;
      if (xret_is_mret) begin
        np = st[12:11];
        st[3] = st[7]; st[7] = 1'b1; st[12:11] = 2'b00;
        if (np != 2'b11) st[17] = 1'b0;
        vec = mepc;
      end else begin
        np = {1'b0, st[8]};
        st[1] = st[5]; st[5] = 1'b1; st[8] = 1'b0; st[17] = 1'b0;
        vec = sepc;
      end
      q.push_back(mk(1, 1, 12'h300, st, 0, 0));
      q.push_back(mk(1, 0, 12'h000, 0, 1, vec));
      mp = np;
    end
  endtask

  // One clock: model sees the request at the edge, then outputs are compared mid-cycle
  task automatic step(input int k);
    obs_t a, e;
    model_accept();
    @(negedge clk);
    a = '{ready, flush, csr_we, csr_addr, csr_wdata, rv, rpc, priv};
    if (k >= 0 && k < 8) cap[k] = a;
    if (q.size() != 0) begin
      e = q.pop_front();
      cur_idle = 0;
    end else begin
      e = mk(0, 0, 0, 0, 0, 0);
      cur_idle = 1;
    end
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL cycle t=%0t got %h expected %h", $time, a, e);
  endtask

  task automatic req();
    step(1);
    clr();
    for (int k = 2; k < 8; k++) step(k);
  endtask

  task automatic chk_reset_outputs(input string p);
    chk({p, "_ready"}, 64'(ready), 64'd1);
    chk({p, "_flush"}, 64'(flush), 64'd0);
    chk({p, "_we"}, 64'(csr_we), 64'd0);
    chk({p, "_addr"}, 64'(csr_addr), 64'd0);
    chk({p, "_wdata"}, csr_wdata, 64'd0);
    chk({p, "_rv"}, 64'(rv), 64'd0);
    chk({p, "_rpc"}, rpc, 64'd0);
    chk({p, "_priv"}, 64'(priv), 64'd3);
  endtask

  initial begin
    clr();
    #1 rstn = 0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rstn = 1;
    mp = 2'b11;
    cur_idle = 1;
    // M-mode synchronous trap
    exc.valid = 1; exc.cause = 64'd2; exc.tval = 64'hDEAD; exc_pc = 64'h8000_0102;
    mtvec = 64'h8000_0000; mstatus = 64'h8;
    req();
    chk("mtrap_addr1", 64'(cap[1].addr), 64'h342);
    chk("mtrap_data1", cap[1].data, 64'd2);
    chk("mtrap_epc", cap[2].data, 64'h8000_0100);
    chk("mtrap_tval", cap[3].data, 64'hDEAD);
    chk("mtrap_status", cap[4].data, 64'h1880);
    chk("mtrap_rpc", cap[5].rpc, 64'h8000_0000);
    chk("mtrap_rv", 64'(cap[5].rv), 64'd1);
    chk("mtrap_ready6", 64'(cap[6].ready), 64'd1);
    chk("mtrap_priv", 64'(cap[6].priv), 64'd3);
    // MRET to S
    xret_valid = 1; xret_is_mret = 1; mstatus = 64'h2_0880; mepc = 64'h2000;
    req();
    chk("mret_addr", 64'(cap[1].addr), 64'h300);
    chk("mret_status", cap[1].data, 64'h88);
    chk("mret_rpc", cap[2].rpc, 64'h2000);
    chk("mret_ready3", 64'(cap[3].ready), 64'd1);
    chk("mret_priv", 64'(cap[3].priv), 64'd1);
    // Vectored interrupt from S, not delegated
    exc.valid = 1; exc.cause = 64'h8000_0000_0000_0007; mtvec = 64'h1001;
    req();
    chk("vec_rpc", cap[5].rpc, 64'h101C);
    chk("vec_priv", 64'(cap[6].priv), 64'd3);
    // MRET to U, then a delegated trap from U
    xret_valid = 1; xret_is_mret = 1; mepc = 64'h3000;
    req();
    chk("mret_u_status", cap[1].data, 64'h80);
    chk("mret_u_priv", 64'(cap[3].priv), 64'd0);
    exc.valid = 1; exc.cause = 64'd8; exc.tval = 64'h55; stvec = 64'h4000;
    medeleg = 64'h100; mstatus = 64'hA000_0000_0000_1802;
    req();
    chk("deleg_addr1", 64'(cap[1].addr), 64'h142);
    chk("deleg_addr2", 64'(cap[2].addr), 64'h141);
    chk("deleg_addr3", 64'(cap[3].addr), 64'h143);
    chk("deleg_status", cap[4].data, 64'hA000_0000_0000_1820);
    chk("deleg_rpc", cap[5].rpc, 64'h4000);
    chk("deleg_priv", 64'(cap[6].priv), 64'd1);
    // Collision: exception beats xRET; a held second exception waits for IDLE
    exc.valid = 1; exc.cause = 64'd2; xret_valid = 1; xret_is_mret = 1; mstatus = 64'h1800;
    step(1);
    xret_valid = 0;
    exc.cause = 64'd5;
    for (int k = 2; k < 8; k++) step(k);
    clr();
    chk("coll_addr1", 64'(cap[1].addr), 64'h342);
    chk("coll_addr2", 64'(cap[2].addr), 64'h341);
    chk("busy_ready", 64'(cap[2].ready), 64'd0);
    chk("busy_ready6", 64'(cap[6].ready), 64'd1);
    chk("busy_second", cap[7].data, 64'd5);
    repeat (8) step(-1);
    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      randomize_inputs();
      step(-1);
    end
    clr();
    repeat (8) step(-1);
    // Reset in W_TVAL aborts the sequence immediately
    exc.valid = 1; exc.cause = 64'd3; exc.tval = 64'h77;
    step(1);
    clr();
    step(2);
    @(posedge clk);
    #2 chk("pre_rst_addr", 64'(csr_addr), (mp == 2'b01) ? 64'h143 : 64'h343);
    rstn = 0;
    #1 chk_reset_outputs("midrst");
    q.delete();
    mp = 2'b11;
    cur_idle = 1;
    @(negedge clk);
    rstn = 1;
    repeat (8) step(-1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
